vec_mem_sequencer: RTL and testbench

//  Serialises one vector load/store from the R-lane datapath over a single N-bit memory port, one lane per beat.

---
 rtl/vec_pkg.sv | 11 +
 rtl/vec_mem_sequencer_if.sv | 17 +
 rtl/vec_lane_cursor.sv | 92 +++++++++
 rtl/vec_mem_sequencer.sv | 100 ++++++++++
 tb/tb_vec_mem_sequencer.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vec_pkg.sv
// Shared types and default geometry for the vector memory sequencer.
package vec_pkg;
    localparam int VEC_I      = 32;
    localparam int VEC_N      = 8;
    localparam int VEC_R      = 6;
    localparam int VEC_STRIDE = 1;
    localparam int LANE_W     = $clog2(VEC_R);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} vseq_state_t;
    typedef logic [LANE_W-1:0] lane_idx_t;
endpackage

// File: rtl/vec_mem_sequencer_if.sv
// Single-beat data memory port: registered request side, ack may come back in the request cycle.
interface vec_mem_sequencer_if
    import vec_pkg::*;
#(
    parameter int I = VEC_I,
    parameter int N = VEC_N
) ();
    logic         mem_req;
    logic         mem_we;
    logic [I-1:0] mem_addr;
    logic [N-1:0] mem_wdata;
    logic [N-1:0] mem_rdata;
    logic         mem_ack;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
    modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/vec_lane_cursor.sv
// Lane cursor: current lane index and address, advanced one enabled lane per step.
// With VMASK_EN it skips disabled lanes; otherwise it is a plain counter from lane 0.
module vec_lane_cursor
    import vec_pkg::*;
#(
    parameter int I      = VEC_I,
    parameter int R      = VEC_R,
    parameter int STRIDE = VEC_STRIDE
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic         step_i,
    input  logic [I-1:0] base_i,
`ifdef VMASK_EN
    input  logic [R-1:0] mask_i,
    output logic         any_o,
`endif
    output lane_idx_t    lane_o,
    output logic [I-1:0] addr_o,
    output logic         last_o
);
    lane_idx_t    lane_q, lane_d;
    logic [I-1:0] addr_q, addr_d;

`ifdef VMASK_EN
    logic [R-1:0] mask_q;
    lane_idx_t    first_lane, next_lane;
    logic         next_vld;

    // Downward scan so the lowest qualifying lane is the one left standing.
    always_comb begin
        first_lane = '0;
        next_lane  = '0;
        next_vld   = 1'b0;
        for (int i = R - 1; i >= 0; i--) begin
            if (mask_i[i]) first_lane = lane_idx_t'(i);
            if (mask_q[i] && (lane_idx_t'(i) > lane_q)) begin
                next_lane = lane_idx_t'(i);
                next_vld  = 1'b1;
            end
        end
    end

    assign any_o  = |mask_i;
    assign last_o = ~next_vld;

    always_comb begin
        lane_d = lane_q;
        addr_d = addr_q;
        if (load_i) begin
            lane_d = first_lane;
            addr_d = base_i + I'(first_lane) * I'(STRIDE);
        end else if (step_i) begin
            lane_d = next_lane;
            addr_d = addr_q + (I'(next_lane) - I'(lane_q)) * I'(STRIDE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset)       mask_q <= '0;
        else if (load_i) mask_q <= mask_i;
    end
`else
    assign last_o = (lane_q == lane_idx_t'(R - 1));

    always_comb begin
        lane_d = lane_q;
        addr_d = addr_q;
        if (load_i) begin
            lane_d = '0;
            addr_d = base_i;
        end else if (step_i) begin
            lane_d = lane_q + 1'b1;
            addr_d = addr_q + I'(STRIDE);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            lane_q <= '0;
            addr_q <= '0;
        end else begin
            lane_q <= lane_d;
            addr_q <= addr_d;
        end
    end

    assign lane_o = lane_q;
    assign addr_o = addr_q;
endmodule

// File: rtl/vec_mem_sequencer.sv
// Serialises one R-lane vector load/store onto a single N-bit memory port, one lane per acked beat;
// lane 0 issues the cycle after accept, done pulses after the last ack. Optional lane masking: VMASK_EN.
module vec_mem_sequencer
    import vec_pkg::*;
#(
    parameter int I      = VEC_I,
    parameter int N      = VEC_N,
    parameter int R      = VEC_R,
    parameter int STRIDE = VEC_STRIDE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                is_store,
    input  logic [I-1:0]        base_addr,
    input  logic [R-1:0][N-1:0] wdata,
`ifdef VMASK_EN
    input  logic [R-1:0]        lane_mask,
`endif
    vec_mem_sequencer_if.master mem,
    output logic                stall,
    output logic                done,
    output logic [R-1:0][N-1:0] rdata
);
    vseq_state_t         state_q, state_d;
    logic                store_q;
    logic                req_q;
    logic                we_q;
    logic [R-1:0][N-1:0] wdata_q;
    logic [R-1:0][N-1:0] rdata_q;

    lane_idx_t           cur_lane;
    logic [I-1:0]        cur_addr;
    logic                last_lane;
    logic                accept;
    logic                beat_done;
    logic                any_lane;

    assign accept    = (state_q == IDLE) && start;
    assign beat_done = (state_q == ACCESS) && mem.mem_ack;

    vec_lane_cursor #(.I(I), .R(R), .STRIDE(STRIDE)) u_cursor (
        .clk    (clk),
        .reset  (reset),
        .load_i (accept),
        .step_i (beat_done && !last_lane),
        .base_i (base_addr),
`ifdef VMASK_EN
        .mask_i (lane_mask),
        .any_o  (any_lane),
`endif
        .lane_o (cur_lane),
        .addr_o (cur_addr),
        .last_o (last_lane)
    );

`ifndef VMASK_EN
    assign any_lane = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = any_lane ? ACCESS : DONE;
            ACCESS:  if (beat_done && last_lane) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            store_q <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= (state_d == ACCESS);
            we_q    <= (state_d == ACCESS) && (accept ? is_store : store_q);
            if (accept) begin
                store_q <= is_store;
                wdata_q <= wdata;
            end
            if (beat_done && !store_q) rdata_q[cur_lane] <= mem.mem_rdata;
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = cur_addr;
    assign mem.mem_wdata = wdata_q[cur_lane];

    // The issuing instruction must freeze in its own accept cycle, hence the combinational start term.
    assign stall = (state_q == ACCESS) || accept;
    assign done  = (state_q == DONE);
    assign rdata = rdata_q;
endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Randomized bench for vec_mem_sequencer with a queue-based beat model and a sparse memory model.
module tb_vec_mem_sequencer;
    localparam int STRIDE = 1;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [7:0]  wd;
        int          lane;
        int          dly;
    } beat_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              is_store;
    logic [31:0]       base_addr;
    logic [5:0][7:0]   wdata;
`ifdef VMASK_EN
    logic [5:0]        lane_mask;
`endif
    logic              stall;
    logic              done;
    logic [5:0][7:0]   rdata;

    vec_mem_sequencer_if #(.I(32), .N(8)) mif ();

    vec_mem_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_store  (is_store),
        .base_addr (base_addr),
        .wdata     (wdata),
`ifdef VMASK_EN
        .lane_mask (lane_mask),
`endif
        .mem       (mif),
        .stall     (stall),
        .done      (done),
        .rdata     (rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  mem_m [bit [31:0]];
    logic [47:0] rd_model = '0;
    beat_t       exp_q [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic run_op(input bit st, input logic [31:0] base, input logic [47:0] wd,
                          input logic [5:0] msk, input int dmode, input bit pulse, input int abort_lane);
        beat_t       b;
        logic [47:0] rd_next;
        int          total;
        int          t;
        int          wcnt;
        bit          fin;
        bit          aborted;
`ifndef VMASK_EN
        msk = '1;
`endif
        exp_q.delete();
        total   = 0;
        rd_next = rd_model;
        for (int k = 0; k < 6; k++) begin
            if (msk[k]) begin
                b.addr = base + 32'(k * STRIDE);
                b.we   = st;
                b.wd   = wd[k*8 +: 8];
                b.lane = k;
                b.dly  = (dmode < 0) ? int'($urandom_range(0, 3)) : dmode;
                if (!st) begin
                    if (!mem_m.exists(b.addr)) mem_m[b.addr] = 8'($urandom);
                    rd_next[k*8 +: 8] = mem_m[b.addr];
                end
                total += b.dly + 1;
                exp_q.push_back(b);
            end
        end

        @(negedge clk);
        start     = 1'b1;
        is_store  = st;
        base_addr = base;
        wdata     = wd;
`ifdef VMASK_EN
        lane_mask = msk;
`endif
        mif.mem_ack = 1'b0;
        #1 chk("stall_accept", 64'(stall), 64'(1));
        t = cyc; wcnt = 0; fin = 0; aborted = 0;

        for (int n = 1; n <= 300 && !fin; n++) begin
            @(negedge clk);
            if (pulse && n == 2) begin
                start     = 1'b0;
                is_store  = ~st;
                base_addr = $urandom;
                wdata     = 48'({$urandom, $urandom});
            end
            if (pulse && n == 3) start = 1'b1;
            mif.mem_ack   = 1'b0;
            mif.mem_rdata = 8'($urandom);
            if (mif.mem_req) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 64'(1), 64'(0));
                    mif.mem_ack = 1'b1;
                end else begin
                    b = exp_q[0];
                    if (abort_lane == b.lane) begin
                        reset   = 1'b1;
                        start   = 1'b0;
                        aborted = 1;
                        fin     = 1;
                    end else begin
                        chk("beat_addr", 64'(mif.mem_addr), 64'(b.addr));
                        chk("beat_we", 64'(mif.mem_we), 64'(b.we));
                        chk("beat_wdata", 64'(mif.mem_wdata), 64'(b.wd));
                        if (wcnt == b.dly) begin
                            mif.mem_ack = 1'b1;
                            wcnt = 0;
                            void'(exp_q.pop_front());
                            if (mif.mem_we) mem_m[mif.mem_addr] = mif.mem_wdata;
                            else mif.mem_rdata = mem_m.exists(mif.mem_addr) ? mem_m[mif.mem_addr] : 8'h00;
                        end else begin
                            wcnt++;
                        end
                    end
                end
            end else begin
                mif.mem_ack = 1'($urandom);
            end
            if (!aborted) begin
                #1;
                if (done) begin
                    chk("done_cycle", 64'(cyc - t), 64'(total + 1));
                    chk("req_in_done", 64'(mif.mem_req), 64'(0));
                    chk("stall_in_done", 64'(stall), 64'(0));
                    chk("rdata", 64'(rdata), 64'(rd_next));
                    chk("beats_left", 64'(exp_q.size()), 64'(0));
                    fin = 1;
                end else begin
                    chk("stall_busy", 64'(stall), 64'(1));
                end
            end
        end

        if (aborted) begin
            @(negedge clk);
            mif.mem_ack = 1'b0;
            #1;
            chk("rst_req", 64'(mif.mem_req), 64'(0));
            chk("rst_we", 64'(mif.mem_we), 64'(0));
            chk("rst_addr", 64'(mif.mem_addr), 64'(0));
            chk("rst_stall", 64'(stall), 64'(0));
            chk("rst_done", 64'(done), 64'(0));
            chk("rst_rdata", 64'(rdata), 64'(0));
            rd_model = '0;
            reset    = 1'b0;
            exp_q.delete();
        end else if (!fin) begin
            chk("timeout", 64'(0), 64'(1));
            @(negedge clk);
            reset = 1'b1;
            start = 1'b0;
            @(negedge clk);
            reset    = 1'b0;
            rd_model = '0;
        end else begin
            rd_model = rd_next;
            @(posedge clk);
            #1 start = 1'b0;
            @(negedge clk);
            mif.mem_ack = 1'b0;
            #1;
            chk("idle_done", 64'(done), 64'(0));
            chk("idle_stall", 64'(stall), 64'(0));
            chk("idle_req", 64'(mif.mem_req), 64'(0));
        end
    endtask

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        is_store      = 1'b0;
        base_addr     = '0;
        wdata         = '0;
`ifdef VMASK_EN
        lane_mask     = '0;
`endif
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_req", 64'(mif.mem_req), 64'(0));
        chk("reset_we", 64'(mif.mem_we), 64'(0));
        chk("reset_addr", 64'(mif.mem_addr), 64'(0));
        chk("reset_wdata", 64'(mif.mem_wdata), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_stall", 64'(stall), 64'(0));
        chk("reset_rdata", 64'(rdata), 64'(0));
        reset = 1'b0;

        // Zero-wait load with known memory contents.
        for (int k = 0; k < 6; k++) mem_m[32'h100 + 32'(k)] = 8'h10 + 8'(k);
        run_op(1'b0, 32'h100, 48'h0, 6'h3F, 0, 1'b0, -1);
        chk("t1_rdata", 64'(rdata), 64'h0000_1514_1312_1110);

        // Store with a two-cycle ack delay, then read it back.
        run_op(1'b1, 32'h300, 48'hA5A4_A3A2_A1A0, 6'h3F, 2, 1'b0, -1);
        run_op(1'b0, 32'h300, 48'h0, 6'h3F, 0, 1'b0, -1);
        chk("t2_readback", 64'(rdata), 64'h0000_A5A4_A3A2_A1A0);

        // Address wrap past the top of the address space.
        run_op(1'b0, 32'hFFFF_FFFE, 48'({$urandom, $urandom}), 6'h3F, 0, 1'b0, -1);

        // Reset during the lane-2 beat of a store, then a clean repeat of the first load.
        run_op(1'b1, 32'h200, 48'({$urandom, $urandom}), 6'h3F, 1, 1'b0, 2);
        run_op(1'b0, 32'h100, 48'h0, 6'h3F, 0, 1'b0, -1);
        chk("t4_rdata", 64'(rdata), 64'h0000_1514_1312_1110);

        // start dropped and re-raised mid-op with scrambled operands, held through DONE.
        run_op(1'b0, 32'h400, 48'({$urandom, $urandom}), 6'h3F, 1, 1'b1, -1);

`ifdef VMASK_EN
        run_op(1'b0, 32'h500, 48'h0, 6'b100101, 0, 1'b0, -1);
        run_op(1'b0, 32'h600, 48'h0, 6'b000000, 0, 1'b0, -1);
`endif

        for (int i = 0; i < 30; i++) begin
            run_op(1'($urandom), (i % 2 == 0) ? 32'($urandom_range(0, 15)) : $urandom,
                   48'({$urandom, $urandom}), 6'($urandom), -1, (i % 4) == 1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
